// File: rtl/timing_sequencer.sv
// One-hot beat generator (T0..T7) for the instruction controller with run/pause/halt
// control and a retired-instruction counter. Define TIMING_STALL_EN to add a stall input.
module timing_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HALT_OP = 4'b0011
) (
    input  logic             clk,
    input  logic             rst,
`ifdef TIMING_STALL_EN
    input  logic             stall,
`endif
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic [3:0]       op,
    output logic [7:0]       T,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALTED} state_t;

    state_t     state, state_n;
    logic [7:0] t_n;
    logic       retire;
    logic       hold;
    logic       onehot;
    logic       muldiv;

`ifdef TIMING_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign onehot = (T != 8'h00) && ((T & (T - 8'h01)) == 8'h00);
    assign muldiv = (op == 4'b0100) || (op == 4'b0101);

    always_comb begin
        state_n = state;
        t_n     = T;
        retire  = 1'b0;
        case (state)
            IDLE, HALTED: begin
                if (T != 8'h00) begin
                    state_n = IDLE;
                    t_n     = 8'h00;
                end else if (start) begin
                    state_n = RUN;
                    t_n     = 8'h01;
                end
            end
            RUN: begin
                // A corrupted beat vector is never propagated; drop back to IDLE.
                if (!onehot) begin
                    state_n = IDLE;
                    t_n     = 8'h00;
                end else if (!hold) begin
                    if (T == 8'h08 && op == HALT_OP) begin
                        state_n = HALTED;
                        t_n     = 8'h00;
                        retire  = 1'b1;
                    end else if (T == 8'h80 || (T == 8'h40 && !muldiv)) begin
                        retire = 1'b1;
                        if (step_mode) begin
                            state_n = PAUSE;
                            t_n     = 8'h00;
                        end else begin
                            t_n = 8'h01;
                        end
                    end else begin
                        t_n = T << 1;
                    end
                end
            end
            PAUSE: begin
                if (T != 8'h00) begin
                    state_n = IDLE;
                    t_n     = 8'h00;
                end else if (step || !step_mode) begin
                    state_n = RUN;
                    t_n     = 8'h01;
                end
            end
            default: begin
                state_n = IDLE;
                t_n     = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            T         <= 8'h00;
            running   <= 1'b0;
            halted    <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state   <= state_n;
            T       <= t_n;
            running <= (state_n == RUN);
            halted  <= (state_n == HALTED);
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Scoreboard bench for timing_sequencer: the driver queues the expected registered
// outputs for each clock, the monitor pops and compares them on the falling edge.
module tb_timing_sequencer;

    localparam int         CNT_W = 4;
    localparam logic [3:0] HALT  = 4'b0011;
    localparam logic [3:0] ADD   = 4'b0001;
    localparam logic [3:0] MUL   = 4'b0100;
    localparam logic [3:0] DIV   = 4'b0101;

    typedef struct packed {
        logic [7:0]       t;
        logic             run;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             start = 1'b0;
    logic             step_mode = 1'b0;
    logic             step = 1'b0;
    logic [3:0]       op = 4'b0000;
    logic [7:0]       T;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    exp_t             q[$];
    exp_t             cur;
    logic [CNT_W-1:0] mcnt = '0;
    logic             async_probe = 1'b0;
    logic             end_probe = 1'b0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    timing_sequencer #(.CNT_W(CNT_W), .HALT_OP(HALT)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TIMING_STALL_EN
        .stall     (stall),
`endif
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .op        (op),
        .T         (T),
        .running   (running),
        .halted    (halted),
        .instr_cnt (instr_cnt)
    );

    // Monitor: the only process that touches the check counters.
    always @(negedge clk or posedge async_probe or posedge end_probe) begin
        if (end_probe) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            checks++;
            if (T !== cur.t || running !== cur.run || halted !== cur.hlt || instr_cnt !== cur.cnt) begin
                errors++;
                $display("FAIL beat @%0t: got T=%h run=%b halt=%b cnt=%0d, required T=%h run=%b halt=%b cnt=%0d",
                         $time, T, running, halted, instr_cnt, cur.t, cur.run, cur.hlt, cur.cnt);
            end
        end
    end

    task automatic drive(input logic s, input logic sm, input logic stp, input logic [3:0] o,
                         input logic [7:0] et, input logic er, input logic eh);
        exp_t e;
        @(negedge clk);
        #1;
        start = s; step_mode = sm; step = stp; op = o;
        e.t = et; e.run = er; e.hlt = eh; e.cnt = mcnt;
        q.push_back(e);
    endtask

    // Starting from T0 on the outputs, play one instruction; op is only meaningful
    // on T3/T6, so every other beat carries HALT as a decoy, plus stray start/step.
    task automatic run_instr(input logic [3:0] o, input logic sm);
        logic [7:0] t;
        logic [3:0] od;
        bit         done;
        t = 8'h01;
        done = 0;
        while (!done) begin
            od = (t == 8'h08 || t == 8'h40) ? o : HALT;
            if (t == 8'h08 && o == HALT) begin
                mcnt++;
                drive(0, sm, 0, od, 8'h00, 0, 1);
                done = 1;
            end else if (t == 8'h80 || (t == 8'h40 && o != MUL && o != DIV)) begin
                mcnt++;
                if (sm) drive(0, sm, 0, od, 8'h00, 0, 0);
                else    drive(0, sm, 0, od, 8'h01, 1, 0);
                done = 1;
            end else begin
                t = t << 1;
                drive(t == 8'h08, sm, t == 8'h04, od, t, 1, 0);
            end
        end
    endtask

    initial begin
        // reset state while rst is held
        q.push_back('{t: 8'h00, run: 1'b0, hlt: 1'b0, cnt: '0});
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        drive(1, 0, 0, ADD, 8'h01, 1, 0);
        run_instr(ADD, 0);
        run_instr(MUL, 0);
        run_instr(DIV, 0);
        run_instr(HALT, 0);
        drive(0, 0, 1, ADD, 8'h00, 0, 1);
        drive(0, 0, 1, MUL, 8'h00, 0, 1);
        drive(1, 1, 0, ADD, 8'h01, 1, 0);
        run_instr(ADD, 1);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, ADD, 8'h00, 0, 0);
        drive(0, 1, 1, ADD, 8'h01, 1, 0);
        run_instr(ADD, 1);
        drive(0, 1, 0, ADD, 8'h00, 0, 0);
        drive(0, 0, 0, ADD, 8'h01, 1, 0);
        run_instr(ADD, 0);

        // asynchronous reset in the middle of T4
        drive(0, 0, 0, ADD, 8'h02, 1, 0);
        drive(0, 0, 0, ADD, 8'h04, 1, 0);
        drive(0, 0, 0, ADD, 8'h08, 1, 0);
        drive(0, 0, 0, ADD, 8'h10, 1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        mcnt = '0;
        q.push_back('{t: 8'h00, run: 1'b0, hlt: 1'b0, cnt: '0});
        #1 async_probe = 1'b1;
        #1 async_probe = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        drive(1, 0, 0, ADD, 8'h01, 1, 0);

        // 16 retirements wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) run_instr(ADD, 0);

`ifdef TIMING_STALL_EN
        drive(0, 0, 0, ADD, 8'h02, 1, 0);
        drive(0, 0, 0, ADD, 8'h04, 1, 0);
        drive(0, 0, 0, ADD, 8'h08, 1, 0);
        stall = 1'b1;
        drive(0, 0, 0, HALT, 8'h08, 1, 0);
        drive(0, 0, 0, HALT, 8'h08, 1, 0);
        drive(0, 0, 0, HALT, 8'h08, 1, 0);
        stall = 1'b0;
        drive(0, 0, 0, ADD, 8'h10, 1, 0);
        drive(0, 0, 0, ADD, 8'h20, 1, 0);
        drive(0, 0, 0, ADD, 8'h40, 1, 0);
        mcnt++;
        drive(0, 0, 0, ADD, 8'h01, 1, 0);
`endif

        for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge clk);
        #1 end_probe = 1'b1;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
